// File: rtl/global_defs_pkg.sv
// Shared definitions for the dot-product accumulator: FSM state encoding,
// the IEEE-754 +0 constant, and the default term count.
package global_defs;

  localparam int unsigned DEFAULT_N_TERMS = 4;
  localparam logic [31:0] FP_POS_ZERO     = 32'h0000_0000;

  typedef enum logic [2:0] {
    LOAD     = 3'd0,
    ACCEPT   = 3'd1,
    ISSUE    = 3'd2,
    WAIT_SUM = 3'd3,
    DONE     = 3'd4
  } accum_state_t;

endpackage

// File: rtl/fpu_dot_accum.sv
// Sequences N_TERMS IEEE-754 single products through an external fpu_adder
// and presents the reduced sum on a valid/ready port.
// Optional FPU_ACCUM_ZERO_SKIP_EN: +/-0 terms after the first bypass the adder.
module fpu_dot_accum
  import global_defs::*;
#(
  parameter int unsigned N_TERMS = DEFAULT_N_TERMS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] term_in,
  input  logic        term_valid,
  output logic        term_ready,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic        add_stb,
  input  logic        add_in_ack,
  input  logic [31:0] add_z,
  input  logic        add_z_stb,
  output logic        add_z_ack,
  output logic [31:0] result,
  output logic        result_valid,
  input  logic        result_ready,
  output logic        busy
);

  localparam int unsigned CW = $clog2(N_TERMS + 1);

  accum_state_t  state, state_n;
  logic [CW-1:0] cnt, cnt_inc;
  logic [31:0]   acc, opb;
  logic          last_term;
  logic          term_xfer;

  assign cnt_inc   = cnt + CW'(1);
  assign last_term = (cnt_inc == CW'(N_TERMS));
  assign term_xfer = term_valid && term_ready;

`ifdef FPU_ACCUM_ZERO_SKIP_EN
  logic zero_term;
  assign zero_term = (term_in[30:0] == 31'd0);
`endif

  always_ff @(posedge clk) begin
    if (!rst) state <= LOAD;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      LOAD:     if (term_xfer) state_n = (N_TERMS == 1) ? DONE : ACCEPT;
      ACCEPT: begin
        if (term_xfer) begin
`ifdef FPU_ACCUM_ZERO_SKIP_EN
          if (zero_term) state_n = last_term ? DONE : ACCEPT;
          else           state_n = ISSUE;
`else
          state_n = ISSUE;
`endif
        end
      end
      ISSUE:    if (add_in_ack) state_n = WAIT_SUM;
      WAIT_SUM: if (add_z_stb)  state_n = last_term ? DONE : ACCEPT;
      DONE:     if (result_ready) state_n = LOAD;
      default:  state_n = LOAD;
    endcase
  end

  // Handshake outputs follow the peer strobes combinationally and stay low in reset.
  always_comb begin
    term_ready   = 1'b0;
    add_stb      = 1'b0;
    add_z_ack    = 1'b0;
    result_valid = 1'b0;
    busy         = 1'b0;
    if (rst) begin
      term_ready   = (state == LOAD) || (state == ACCEPT);
      add_stb      = (state == ISSUE) && add_in_ack;
      add_z_ack    = (state == WAIT_SUM) && add_z_stb;
      result_valid = (state == DONE);
      busy         = (state != LOAD) || (cnt != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc <= FP_POS_ZERO;
      opb <= FP_POS_ZERO;
      cnt <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (term_xfer) begin
            acc <= term_in;
            cnt <= CW'(1);
          end
        end
        ACCEPT: begin
          if (term_xfer) begin
`ifdef FPU_ACCUM_ZERO_SKIP_EN
            if (zero_term) cnt <= cnt_inc;
            else           opb <= term_in;
`else
            opb <= term_in;
`endif
          end
        end
        WAIT_SUM: begin
          if (add_z_ack) begin
            acc <= add_z;
            cnt <= cnt_inc;
          end
        end
        DONE:    if (result_ready) cnt <= '0;
        default: ;
      endcase
    end
  end

  assign add_a  = acc;
  assign add_b  = opb;
  assign result = acc;

endmodule
